serializador_palabra: RTL and testbench

Upstream feeder for the parity cell array (initial cell plus chain of typical cells). It accepts a parallel word over a valid/ready handshake and emits it LSB-first, one bit per clock, on the serial word line `L`. It marks the first and last bit of each frame and, after the last bit, publishes a reference parity bit. The verification bench compares that reference against the array's `I_p` output.

---
 rtl/celda_pkg.sv | 16 +
 rtl/registro_desplazamiento.sv | 28 ++
 rtl/serializador_palabra.sv | 106 ++++++++++
 tb/tb_serializador_palabra.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/celda_pkg.sv
// Shared types and constants for the parity cell array feeder.
// Holds the serializer state encoding, default word width and parity encoding.
package celda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } estado_t;

  localparam int WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/registro_desplazamiento.sv
// Parallel-load, shift-right register; load wins over shift, holds when neither is asserted.
// Zero latency to q0 after the loading edge; no backpressure of its own (shift_en is the stall gate).
module registro_desplazamiento #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= d;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign q0 = shreg[0];

endmodule

// File: rtl/serializador_palabra.sv
// Word-to-bit serializer, LSB first, with frame markers and a reference parity bit after the frame.
// Bit k on L k+1 cycles after accept, done at WIDTH+1; stall freezes SHIFT, load_ready only in IDLE.
module serializador_palabra
  import celda_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             stall,
  output logic             L,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             parity_ref,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  estado_t          state;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             q0;
  logic             do_load;
  logic             do_shift;

  assign load_ready = (state == IDLE);
  assign do_load    = (state == IDLE) && load_valid;
  assign do_shift   = (state == SHIFT) && !stall;

  registro_desplazamiento #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (do_load),
    .shift_en (do_shift),
    .d        (word_in),
    .q0       (q0)
  );

  // bit_valid is registered, so L only ever reflects the register head during SHIFT
  assign L = bit_valid & q0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= PAR_EVEN;
      parity_ref <= PAR_EVEN;
      bit_valid  <= 1'b0;
      first_bit  <= 1'b0;
      last_bit   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            state     <= SHIFT;
            cnt       <= '0;
            acc       <= PAR_EVEN;
            bit_valid <= 1'b1;
            first_bit <= 1'b1;
            last_bit  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!stall) begin
            acc       <= acc ^ q0;
            first_bit <= 1'b0;
            // cnt stops at WIDTH-1 rather than wrapping on the final bit
            if (cnt == CNT_LAST) begin
              state      <= DONE;
              bit_valid  <= 1'b0;
              last_bit   <= 1'b0;
              done       <= 1'b1;
              parity_ref <= acc ^ q0;
            end else begin
              cnt      <= cnt + 1'b1;
              last_bit <= (cnt == CNT_PENULT);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
          first_bit <= 1'b0;
          last_bit  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_palabra.sv
// Directed bench for serializador_palabra (WIDTH=8) with hand-computed bit sequences and parities.
module tb_serializador_palabra;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] word_in;
  logic         load_valid;
  logic         load_ready;
  logic         stall;
  logic         L;
  logic         bit_valid;
  logic         first_bit;
  logic         last_bit;
  logic         parity_ref;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  serializador_palabra #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_in    (word_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .stall      (stall),
    .L          (L),
    .bit_valid  (bit_valid),
    .first_bit  (first_bit),
    .last_bit   (last_bit),
    .parity_ref (parity_ref),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one frame; exp_bits is the hand-derived L sequence (index = bit position).
  // The stall is raised for stall_cyc cycles while bit stall_bit is shown;
  // a stray load of 8'h3C is offered while bit inj_bit is shown.
  task automatic run_frame(input string tag, input logic [W-1:0] w, input logic [W-1:0] exp_bits,
                           input logic exp_par, input int stall_bit, input int stall_cyc,
                           input int inj_bit);
    int hold;
    int cyc;
    @(negedge clk);
    word_in    = w;
    load_valid = 1'b1;
    chk($sformatf("%s_rdy_idle", tag), load_ready, 1'b1);
    cyc = 0;
    for (int k = 0; k < W; k++) begin
      hold = (k == stall_bit) ? stall_cyc + 1 : 1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        cyc++;
        load_valid = 1'b0;
        chk($sformatf("%s_L%0d_%0d", tag, k, h), L, exp_bits[k]);
        chk($sformatf("%s_bv%0d", tag, k), bit_valid, 1'b1);
        chk($sformatf("%s_first%0d", tag, k), first_bit, (k == 0));
        chk($sformatf("%s_last%0d", tag, k), last_bit, (k == W - 1));
        chk($sformatf("%s_rdy%0d", tag, k), load_ready, 1'b0);
        chk($sformatf("%s_done%0d", tag, k), done, 1'b0);
        if (k == stall_bit && stall_cyc > 0) stall = (h < stall_cyc);
        if (k == inj_bit && h == 0) begin
          word_in    = 8'h3C;
          load_valid = 1'b1;
        end
      end
    end
    @(negedge clk);
    cyc++;
    load_valid = 1'b0;
    chk($sformatf("%s_done", tag), done, 1'b1);
    chk($sformatf("%s_done_cyc", tag), cyc, W + 1 + ((stall_bit >= 0) ? stall_cyc : 0));
    chk($sformatf("%s_par", tag), parity_ref, exp_par);
    chk($sformatf("%s_bv_done", tag), bit_valid, 1'b0);
    chk($sformatf("%s_rdy_done", tag), load_ready, 1'b0);
    @(negedge clk);
    chk($sformatf("%s_done_pulse", tag), done, 1'b0);
    chk($sformatf("%s_rdy_back", tag), load_ready, 1'b1);
    chk($sformatf("%s_par_hold", tag), parity_ref, exp_par);
    chk($sformatf("%s_bv_idle", tag), bit_valid, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    word_in    = '0;
    load_valid = 1'b0;
    stall      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", load_ready, 1'b1);
    chk("rst_L", L, 1'b0);
    chk("rst_bv", bit_valid, 1'b0);
    chk("rst_first", first_bit, 1'b0);
    chk("rst_last", last_bit, 1'b0);
    chk("rst_par", parity_ref, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1011_0010 -> L = 0,1,0,0,1,1,0,1 (index 0 first), four ones -> even
    run_frame("basic", 8'b1011_0010, 8'b1011_0010, 1'b0, -1, 0, -1);
    // 0x01 -> 1 then seven 0s, odd
    run_frame("odd", 8'h01, 8'b0000_0001, 1'b1, -1, 0, -1);
    // 0xA5 -> 1,0,1,0,0,1,0,1; bit 2 held 4 cycles, done at cycle 12
    run_frame("stall", 8'hA5, 8'b1010_0101, 1'b0, 2, 3, -1);
    // 0x81 -> 1,0,0,0,0,0,0,1 with a stray 0x3C offered during bit 3
    run_frame("ign", 8'h81, 8'b1000_0001, 1'b0, -1, 0, 3);
    // 0x07 -> three ones, odd; leaves parity_ref=1 for the reset check
    run_frame("odd3", 8'h07, 8'b0000_0111, 1'b1, -1, 0, -1);

    // Reset mid-frame: 0xFF, abort while bit 3 is on L
    @(negedge clk);
    word_in    = 8'hFF;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bv_pre", bit_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_L", L, 1'b0);
    chk("mid_bv", bit_valid, 1'b0);
    chk("mid_first", first_bit, 1'b0);
    chk("mid_last", last_bit, 1'b0);
    chk("mid_par", parity_ref, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_rdy", load_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_nodone%0d", i), done, 1'b0);
      chk($sformatf("mid_idle%0d", i), load_ready, 1'b1);
    end

    // Back-to-back: load_valid held high, 0xFF then 0x00
    @(negedge clk);
    word_in    = 8'hFF;
    load_valid = 1'b1;
    for (int c = 1; c <= 2 * (W + 2); c++) begin
      @(negedge clk);
      if (c == 1) word_in = 8'h00;
      if (c <= W) begin
        chk($sformatf("b2b_L%0d", c), L, (c <= W) ? 1'b1 : 1'b0);
        chk($sformatf("b2b_rdy%0d", c), load_ready, 1'b0);
      end else if (c == W + 1) begin
        chk("b2b_done1", done, 1'b1);
        chk("b2b_par1", parity_ref, 1'b0);
        chk("b2b_rdy_done1", load_ready, 1'b0);
      end else if (c == W + 2) begin
        chk("b2b_rdy_gap", load_ready, 1'b1);
        chk("b2b_bv_gap", bit_valid, 1'b0);
      end else if (c == W + 3) begin
        chk("b2b_first2", first_bit, 1'b1);
        chk("b2b_bv2", bit_valid, 1'b1);
        chk("b2b_L2", L, 1'b0);
        load_valid = 1'b0;
      end else if (c < 2 * W + 3) begin
        chk($sformatf("b2b_rdy2_%0d", c), load_ready, 1'b0);
        chk($sformatf("b2b_L2_%0d", c), L, 1'b0);
      end else if (c == 2 * W + 3) begin
        chk("b2b_done2", done, 1'b1);
        chk("b2b_par2", parity_ref, 1'b0);
      end else begin
        chk($sformatf("b2b_idle%0d", c), load_ready, 1'b1);
        chk($sformatf("b2b_nodone%0d", c), done, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
